// File: rtl/fpalu_pkg.sv
// rtl/fpalu_pkg.sv - shared field layout, constants and state encoding for the FP ALU
package fpalu_pkg;

    localparam int SIGN_BIT = 31;
    localparam int EXP_HI   = 30;
    localparam int EXP_LO   = 23;
    localparam int FRAC_HI  = 22;
    localparam int FRAC_LO  = 0;

    localparam logic [7:0]  EXP_MAX = 8'd255;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        ALIGN,
        ADD,
        NORM,
        PACK,
        DONE
    } state_t;

    // Unpacked operand: sig is {guard 0, hidden 1, frac}, all zero for a zero operand
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [24:0] sig;
    } fp_op_t;

endpackage

// File: rtl/fp_unpack.sv
// rtl/fp_unpack.sv - flush-to-zero, special detection and magnitude swap of an operand pair
module fp_unpack
    import fpalu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        invalid,
    output fp_op_t      op_big,
    output fp_op_t      op_small
);

    fp_op_t      ua;
    fp_op_t      ub;
    logic [30:0] mag_a;
    logic [30:0] mag_b;

    // Unpack both operands, then order them so op_big holds the larger magnitude (ties keep a first)
    always_comb begin
        invalid = (a[EXP_HI:EXP_LO] == EXP_MAX) || (b[EXP_HI:EXP_LO] == EXP_MAX);

        ua.sign = a[SIGN_BIT];
        ub.sign = b[SIGN_BIT];
        ua.exp  = a[EXP_HI:EXP_LO];
        ub.exp  = b[EXP_HI:EXP_LO];
        ua.sig  = {2'b01, a[FRAC_HI:FRAC_LO]};
        ub.sig  = {2'b01, b[FRAC_HI:FRAC_LO]};
        if (a[EXP_HI:EXP_LO] == 8'd0) begin
            ua.sig = '0;
        end
        if (b[EXP_HI:EXP_LO] == 8'd0) begin
            ub.sig = '0;
        end

        mag_a = {ua.exp, ua.sig[FRAC_HI:FRAC_LO]};
        mag_b = {ub.exp, ub.sig[FRAC_HI:FRAC_LO]};

        if (mag_b > mag_a) begin
            op_big   = ub;
            op_small = ua;
        end else begin
            op_big   = ua;
            op_small = ub;
        end
    end

endmodule

// File: rtl/fpalu_sub_seq.sv
// rtl/fpalu_sub_seq.sv - multi-cycle handshaked single-precision subtractor, one shift bit per clock
module fpalu_sub_seq
    import fpalu_pkg::*;
#(
    parameter int ALIGN_CAP = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] diff,
    output logic [2:0]  flags
);

    localparam logic [7:0] CAP = 8'(ALIGN_CAP);

    state_t      state_q,     state_d;
    logic        in_ready_q,  in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] opa_q,       opa_d;
    logic [31:0] opb_q,       opb_d;
    logic        sign_q,      sign_d;
    logic        signb_q,     signb_d;
    logic [7:0]  exp_q,       exp_d;
    logic [24:0] sig_q,       sig_d;
    logic [24:0] sigb_q,      sigb_d;
    logic [7:0]  cnt_q,       cnt_d;
    logic        inv_q,       inv_d;
    logic        ovf_q,       ovf_d;
    logic        unf_q,       unf_d;
    logic [31:0] diff_q,      diff_d;
    logic [2:0]  flags_q,     flags_d;

    logic        u_invalid;
    fp_op_t      u_big;
    fp_op_t      u_small;
    logic [7:0]  exp_gap;

    fp_unpack u_unpack (
        .a        (opa_q),
        .b        (opb_q),
        .invalid  (u_invalid),
        .op_big   (u_big),
        .op_small (u_small)
    );

    assign exp_gap   = u_big.exp - u_small.exp;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign flags     = flags_q;

    // Sequencer and datapath next-state: one pipeline step or one shift bit per clock
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sign_d  = sign_q;
        signb_d = signb_q;
        exp_d   = exp_q;
        sig_d   = sig_q;
        sigb_d  = sigb_q;
        cnt_d   = cnt_q;
        inv_d   = inv_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        diff_d  = diff_q;
        flags_d = flags_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    opa_d   = a_in;
                    opb_d   = {~b_in[SIGN_BIT], b_in[EXP_HI:FRAC_LO]};
                    inv_d   = 1'b0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                if (u_invalid) begin
                    inv_d   = 1'b1;
                    state_d = PACK;
                end else begin
                    sign_d  = u_big.sign;
                    signb_d = u_small.sign;
                    exp_d   = u_big.exp;
                    sig_d   = u_big.sig;
                    sigb_d  = u_small.sig;
                    cnt_d   = (exp_gap > CAP) ? CAP : exp_gap;
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                if (cnt_q == 8'd0) begin
                    state_d = ADD;
                end else begin
                    sigb_d = sigb_q >> 1;
                    cnt_d  = cnt_q - 8'd1;
                end
            end
            ADD: begin
                sig_d   = (sign_q == signb_q) ? (sig_q + sigb_q) : (sig_q - sigb_q);
                state_d = NORM;
            end
            NORM: begin
                if (sig_q == '0) begin
                    sign_d  = 1'b0;
                    exp_d   = 8'd0;
                    state_d = PACK;
                end else if (sig_q[24]) begin
                    sig_d   = sig_q >> 1;
                    exp_d   = exp_q + 8'd1;
                    if (exp_q == EXP_MAX - 8'd1) begin
                        ovf_d = 1'b1;
                    end
                    state_d = PACK;
                end else if (sig_q[23]) begin
                    state_d = PACK;
                end else begin
                    sig_d = sig_q << 1;
                    exp_d = exp_q - 8'd1;
                    if (exp_q == 8'd1) begin
                        unf_d   = 1'b1;
                        sig_d   = '0;
                        state_d = PACK;
                    end
                end
            end
            PACK: begin
                if (inv_q) begin
                    diff_d = QNAN;
                end else if (ovf_q) begin
                    diff_d = {sign_q, EXP_MAX, 23'd0};
                end else begin
                    diff_d = {sign_q, exp_q, sig_q[FRAC_HI:FRAC_LO]};
                end
                flags_d = {inv_q, ovf_q, unf_q};
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers, all cleared asynchronously by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            opa_q       <= '0;
            opb_q       <= '0;
            sign_q      <= 1'b0;
            signb_q     <= 1'b0;
            exp_q       <= '0;
            sig_q       <= '0;
            sigb_q      <= '0;
            cnt_q       <= '0;
            inv_q       <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            diff_q      <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            sign_q      <= sign_d;
            signb_q     <= signb_d;
            exp_q       <= exp_d;
            sig_q       <= sig_d;
            sigb_q      <= sigb_d;
            cnt_q       <= cnt_d;
            inv_q       <= inv_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            diff_q      <= diff_d;
            flags_q     <= flags_d;
        end
    end

endmodule

// File: tb/tb_fpalu_sub_seq.sv
// tb/tb_fpalu_sub_seq.sv - self-checking bench for fpalu_sub_seq
module tb_fpalu_sub_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic [2:0]  flags;

    int n_cmp  = 0;
    int n_fail = 0;

    fpalu_sub_seq #(.ALIGN_CAP(26)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    // Reference: exact integer arithmetic following the rounding/shift rules of the unit
    function automatic void ref_sub(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic [2:0] f, output int lat);
        logic [31:0] nb;
        logic [31:0] x;
        logic [31:0] y;
        int ma, mb, ex, ey, sx, sy, d, s, e, nshift;
        logic sgx, sgy;
        nb = {~b[31], b[30:0]};
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
            r = 32'h7FC0_0000; f = 3'b100; lat = 2;
            return;
        end
        ma = (a[30:23] == 8'd0) ? 0 : int'(a[30:0]);
        mb = (b[30:23] == 8'd0) ? 0 : int'(b[30:0]);
        if (mb > ma) begin x = nb; y = a; end else begin x = a; y = nb; end
        sgx = x[31];
        sgy = y[31];
        ex  = int'(x[30:23]);
        ey  = int'(y[30:23]);
        sx  = (ex == 0) ? 0 : ((1 << 23) + int'(x[22:0]));
        sy  = (ey == 0) ? 0 : ((1 << 23) + int'(y[22:0]));
        d   = ex - ey;
        if (d > 26) d = 26;
        sy  = sy >> d;
        s   = (sgx == sgy) ? (sx + sy) : (sx - sy);
        e   = ex;
        f   = 3'b000;
        lat = 5 + d;
        if (s == 0) begin
            r = 32'h0;
        end else if (s >= (1 << 24)) begin
            s = s >> 1;
            e = e + 1;
            if (e == 255) begin
                r = {sgx, 8'hFF, 23'h0}; f = 3'b010;
            end else begin
                r = {sgx, e[7:0], s[22:0]};
            end
        end else begin
            nshift = 0;
            while (s < (1 << 23)) begin
                s = s * 2;
                e = e - 1;
                nshift++;
                if (e == 0) break;
            end
            if (e == 0) begin
                // the shift that hits exponent zero also exits, so no trailing check cycle
                r = {sgx, 31'h0}; f = 3'b001; lat = 4 + d + nshift;
            end else begin
                r = {sgx, e[7:0], s[22:0]}; lat = 5 + d + nshift;
            end
        end
    endfunction

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, output int lat, output bit to);
        int w;
        w = 0;
        while (in_ready !== 1'b1 && w < 100) begin
            @(posedge clk); #1; w++;
        end
        a_in = a; b_in = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a_in = '0; b_in = '0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        to = (out_valid !== 1'b1);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (in_ready !== 1'b0)   begin n_fail++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        n_cmp++; if (diff !== 32'h0)      begin n_fail++; $display("FAIL rst_diff got=%h want=0", diff); end
        n_cmp++; if (flags !== 3'b000)    begin n_fail++; $display("FAIL rst_flags got=%b want=000", flags); end
        @(posedge clk); @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b0)   begin n_fail++; $display("FAIL rst_held_in_ready got=%b want=0", in_ready); end
        #1 rst = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b0)   begin n_fail++; $display("FAIL rst_release_in_ready got=%b want=0", in_ready); end
        @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL rst_first_edge_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_directed();
        logic [31:0] va [10];
        logic [31:0] vb [10];
        logic [31:0] vr [10];
        logic [2:0]  vf [10];
        int          vl [10];
        int lat;
        bit to;
        va[0] = 32'h4040_0000; vb[0] = 32'h3F80_0000; vr[0] = 32'h4000_0000; vf[0] = 3'b000; vl[0] = 6;
        va[1] = 32'h3F80_0000; vb[1] = 32'hBF80_0000; vr[1] = 32'h4000_0000; vf[1] = 3'b000; vl[1] = 5;
        va[2] = 32'h3FC0_0000; vb[2] = 32'h3FA0_0000; vr[2] = 32'h3E80_0000; vf[2] = 3'b000; vl[2] = 7;
        va[3] = 32'h3F80_0000; vb[3] = 32'h3F80_0000; vr[3] = 32'h0000_0000; vf[3] = 3'b000; vl[3] = 5;
        va[4] = 32'h7F80_0000; vb[4] = 32'h3F80_0000; vr[4] = 32'h7FC0_0000; vf[4] = 3'b100; vl[4] = 2;
        va[5] = 32'h7F7F_FFFF; vb[5] = 32'hFF7F_FFFF; vr[5] = 32'h7F80_0000; vf[5] = 3'b010; vl[5] = 5;
        va[6] = 32'h3F80_0000; vb[6] = 32'h3300_0000; vr[6] = 32'h3F80_0000; vf[6] = 3'b000; vl[6] = 30;
        va[7] = 32'h3F80_0000; vb[7] = 32'h2B80_0000; vr[7] = 32'h3F80_0000; vf[7] = 3'b000; vl[7] = 31;
        va[8] = 32'h0080_0000; vb[8] = 32'h0080_0001; vr[8] = 32'h8000_0000; vf[8] = 3'b001; vl[8] = 5;
        va[9] = 32'h0000_0001; vb[9] = 32'h3F80_0000; vr[9] = 32'hBF80_0000; vf[9] = 3'b000; vl[9] = 31;
        for (int i = 0; i < 10; i++) begin
            start_op(va[i], vb[i], lat, to);
            n_cmp++; if (to)              begin n_fail++; $display("FAIL dir%0d_timeout no out_valid within 200 edges", i); end
            n_cmp++; if (diff !== vr[i])  begin n_fail++; $display("FAIL dir%0d_diff got=%h want=%h", i, diff, vr[i]); end
            n_cmp++; if (flags !== vf[i]) begin n_fail++; $display("FAIL dir%0d_flags got=%b want=%b", i, flags, vf[i]); end
            n_cmp++; if (lat != vl[i])    begin n_fail++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, vl[i]); end
            consume();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit to;
        start_op(32'h3FC0_0000, 32'h3FA0_0000, lat, to);
        n_cmp++; if (to) begin n_fail++; $display("FAIL bp_timeout no out_valid"); end
        for (int i = 0; i < 10; i++) begin
            a_in = $urandom; b_in = $urandom; in_valid = 1'b1;
            @(posedge clk); #1;
            n_cmp++; if (diff !== 32'h3E80_0000) begin n_fail++; $display("FAIL bp_diff_hold got=%h want=3e800000", diff); end
            n_cmp++; if (out_valid !== 1'b1)     begin n_fail++; $display("FAIL bp_valid_hold got=%b want=1", out_valid); end
            n_cmp++; if (in_ready !== 1'b0)      begin n_fail++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
        end
        in_valid = 1'b0;
        consume();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drop_valid got=%b want=0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL bp_ready_after got=%b want=1", in_ready); end
    endtask

    task automatic test_reset_mid_op();
        int lat;
        bit to;
        logic [31:0] r;
        logic [2:0]  f;
        int          l;
        // reset while aligning a long exponent gap
        a_in = 32'h3F80_0000; b_in = 32'h2B80_0000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out_valid got=%b want=0", out_valid); end
        n_cmp++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL mid_rst_in_ready got=%b want=0", in_ready); end
        n_cmp++; if (diff !== 32'h0)     begin n_fail++; $display("FAIL mid_rst_diff got=%h want=0", diff); end
        @(posedge clk); #2 rst = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL mid_rel_in_ready got=%b want=0", in_ready); end
        @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL mid_edge_in_ready got=%b want=1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_partial got=%b want=0", out_valid); end
        start_op(32'h4040_0000, 32'h3F80_0000, lat, to);
        n_cmp++; if (to || diff !== 32'h4000_0000) begin n_fail++; $display("FAIL mid_next_diff got=%h want=40000000", diff); end
        n_cmp++; if (lat != 6)           begin n_fail++; $display("FAIL mid_next_latency got=%0d want=6", lat); end
        // reset while a result is waiting to be consumed
        ref_sub(32'hC120_0000, 32'h3F00_0000, r, f, l);
        consume();
        start_op(32'hC120_0000, 32'h3F00_0000, lat, to);
        n_cmp++; if (to || diff !== r)   begin n_fail++; $display("FAIL done_pre_diff got=%h want=%h", diff, r); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL done_rst_out_valid got=%b want=0", out_valid); end
        n_cmp++; if (diff !== 32'h0)     begin n_fail++; $display("FAIL done_rst_diff got=%h want=0", diff); end
        n_cmp++; if (flags !== 3'b000)   begin n_fail++; $display("FAIL done_rst_flags got=%b want=000", flags); end
        @(posedge clk); #2 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [31:0] a, b, r;
        logic [2:0]  f;
        int l, lat, ea, eb, sel;
        bit to;
        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 31);
            ea  = (sel == 0) ? 0 : (sel == 1) ? 255 : $urandom_range(1, 254);
            sel = $urandom_range(0, 3);
            case (sel)
                0:       eb = ea;
                1:       eb = ea + $urandom_range(0, 6) - 3;
                2:       eb = $urandom_range(0, 254);
                default: eb = ea - $urandom_range(20, 30);
            endcase
            if (eb < 0) eb = 0;
            if (eb > 254 && ea != 255) eb = 254;
            if (eb > 255) eb = 255;
            a = {1'($urandom_range(0, 1)), 8'(ea), 23'($urandom)};
            b = {1'($urandom_range(0, 1)), 8'(eb), 23'($urandom)};
            if (sel == 0 && $urandom_range(0, 1) == 1) b[22:0] = a[22:0];
            ref_sub(a, b, r, f, l);
            start_op(a, b, lat, to);
            n_cmp++; if (to)         begin n_fail++; $display("FAIL rnd%0d_timeout a=%h b=%h", i, a, b); end
            n_cmp++; if (diff !== r) begin n_fail++; $display("FAIL rnd%0d_diff a=%h b=%h got=%h want=%h", i, a, b, diff, r); end
            n_cmp++; if (flags !== f) begin n_fail++; $display("FAIL rnd%0d_flags a=%h b=%h got=%b want=%b", i, a, b, flags, f); end
            n_cmp++; if (lat != l)   begin n_fail++; $display("FAIL rnd%0d_latency a=%h b=%h got=%0d want=%0d", i, a, b, lat, l); end
            consume();
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
